// File: rtl/rx_pkg.sv
// Shared definitions for the UART-to-SHA-256 word assembler.
// Holds the frame FSM state encoding, word/byte geometry, parameter defaults
// and a width helper used by the assembler and its byte packer.
package rx_pkg;

  localparam int unsigned BYTE_W                  = 8;
  localparam int unsigned BYTES_PER_WORD          = 4;
  localparam int unsigned WORD_W                  = 32;
  localparam int unsigned SHADOW_W                = WORD_W - BYTE_W;
  localparam int unsigned DEFAULT_TIMEOUT         = 12;
  localparam int unsigned DEFAULT_WORDS_PER_BLOCK = 16;

  // One-hot frame FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'b01,
    StArmed = 2'b10
  } rx_state_e;

  // Index width for a counter over n values; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_word_assembler_if.sv
// Message-word handshake bus between the word assembler and the SHA-256
// message scheduler.
//   word        packed word, first received byte in [31:24]
//   word_valid  word holds an unconsumed word
//   word_ready  consumer accepts word
//   word_last   word is the final word of its 512-bit block
interface rx_word_assembler_if
  import rx_pkg::*;
();

  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;

  modport master (
    output word,
    output word_valid,
    output word_last,
    input  word_ready
  );

  modport slave (
    input  word,
    input  word_valid,
    input  word_last,
    output word_ready
  );

endinterface

// File: rtl/rx_word_assembler_byte_packer.sv
// byte_packer: packs good bytes big-endian into 32-bit words and presents them
// on a valid/ready output register; flags the last word of each block and
// records dropped words in a sticky overrun flag.
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_byte_good     i_byte is a good received byte (one-cycle pulse)
//   i_frame_fail    current frame failed; partial word is discarded
//   i_byte          received byte
//   word_if         word handshake bus (master side)
//   o_overrun       sticky: a completed word was dropped
module byte_packer
  import rx_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_byte_good,
  input  logic              i_frame_fail,
  input  logic [BYTE_W-1:0] i_byte,
  rx_word_assembler_if.master word_if,
  output logic              o_overrun
);

  localparam int unsigned ByteIdxW = idx_width(BYTES_PER_WORD);
  localparam int unsigned WordIdxW = idx_width(WORDS_PER_BLOCK);
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(BYTES_PER_WORD - 1);
  localparam logic [WordIdxW-1:0] LastWord = WordIdxW'(WORDS_PER_BLOCK - 1);

  logic [ByteIdxW-1:0] r_byte_idx;
  logic [WordIdxW-1:0] r_word_idx;
  logic [SHADOW_W-1:0] r_shadow;
  logic [WORD_W-1:0]   r_word;
  logic                r_word_valid;
  logic                r_word_last;
  logic                r_overrun;

  logic w_xfer;
  logic w_word_done;
  logic w_drop;

  assign w_xfer      = r_word_valid & word_if.word_ready;
  assign w_word_done = i_byte_good & (r_byte_idx == LastByte);
  // A word finishing while the held one cannot leave this cycle is lost.
  assign w_drop      = w_word_done & r_word_valid & ~word_if.word_ready;

  // Byte index and shadow of the first three bytes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_byte_idx <= '0;
      r_shadow   <= '0;
    end else if (i_frame_fail || w_word_done) begin
      r_byte_idx <= '0;
    end else if (i_byte_good) begin
      r_byte_idx <= r_byte_idx + ByteIdxW'(1);
      r_shadow   <= {r_shadow[SHADOW_W-BYTE_W-1:0], i_byte};
    end
  end

  // Output word register, word index and overrun.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_word_last  <= 1'b0;
      r_word_idx   <= '0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_word_done && !w_drop) begin
        r_word       <= {r_shadow, i_byte};
        r_word_valid <= 1'b1;
        r_word_last  <= (r_word_idx == LastWord);
        r_word_idx   <= (r_word_idx == LastWord) ? '0 : r_word_idx + WordIdxW'(1);
      end else if (w_xfer) begin
        r_word_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign word_if.word       = r_word;
  assign word_if.word_valid = r_word_valid;
  assign word_if.word_last  = r_word_last;
  assign o_overrun          = r_overrun;

endmodule

// File: rtl/rx_word_assembler.sv
// rx_word_assembler: detects UART start bits, releases the external byte
// receiver for exactly one frame, collects its result and packs good bytes
// into SHA-256 message words.
//   i_clk, i_reset   bit-rate clock, synchronous active-high reset
//   i_rx             raw serial line (idle high)
//   o_rx_line        i_rx delayed one cycle, to the byte receiver
//   o_rx_rst_n       active-low reset to the byte receiver
//   i_rx_byte        received byte
//   i_rx_ok          byte receiver: good stop bit
//   i_rx_error       byte receiver: framing error
//   word_if          word handshake bus (master side)
//   o_overrun        sticky: a completed word was dropped
//   o_err_cnt        saturating count of failed frames
module rx_word_assembler
  import rx_pkg::*;
#(
  parameter int unsigned TIMEOUT         = DEFAULT_TIMEOUT,
  parameter int unsigned WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx,
  output logic              o_rx_line,
  output logic              o_rx_rst_n,
  input  logic [BYTE_W-1:0] i_rx_byte,
  input  logic              i_rx_ok,
  input  logic              i_rx_error,
  rx_word_assembler_if.master word_if,
  output logic              o_overrun,
  output logic [7:0]        o_err_cnt
);

  localparam int unsigned TimerW = idx_width(TIMEOUT);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  rx_state_e         r_state;
  rx_state_e         w_state_next;
  logic [TimerW-1:0] r_timer;
  logic              r_rx_line;
  logic [7:0]        r_err_cnt;

  logic w_timeout;
  logic w_frame_fail;
  logic w_byte_good;

  // Line delay: the receiver sees the start bit one cycle after we detect it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_line <= 1'b1;
    end else begin
      r_rx_line <= i_rx;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!i_rx) begin
          w_state_next = StArmed;
        end
      end
      StArmed: begin
        if (w_frame_fail || w_byte_good) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs. Receiver runs only while armed, so it is held in reset
  // for at least the one IDLE cycle between frames.
  always_comb begin
    o_rx_rst_n   = 1'b0;
    w_timeout    = 1'b0;
    w_frame_fail = 1'b0;
    w_byte_good  = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_rx_rst_n = 1'b0;
      end
      StArmed: begin
        o_rx_rst_n   = 1'b1;
        w_timeout    = (r_timer == TimerLast);
        // Framing error beats a simultaneous good flag.
        w_frame_fail = i_rx_error | w_timeout;
        w_byte_good  = i_rx_ok & ~w_frame_fail;
      end
      default: begin
        o_rx_rst_n = 1'b0;
      end
    endcase
  end

  // Frame timer: cleared while idle, counts cycles spent armed.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_timer <= '0;
    end else if (r_state == StArmed) begin
      r_timer <= r_timer + TimerW'(1);
    end else begin
      r_timer <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_cnt <= '0;
    end else if (w_frame_fail && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  byte_packer #(
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
  ) u_byte_packer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_byte_good (w_byte_good),
    .i_frame_fail(w_frame_fail),
    .i_byte      (i_rx_byte),
    .word_if     (word_if),
    .o_overrun   (o_overrun)
  );

  assign o_rx_line = r_rx_line;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_rx_word_assembler.sv
// Testbench for rx_word_assembler with a behavioural byte receiver driven
// serially; words are checked against a queue-based packing model.
module tb_rx_word_assembler;
  import rx_pkg::*;

  localparam int unsigned TIMEOUT = 12;
  localparam int unsigned WPB     = 16;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic       rx_line;
  logic       rx_rst_n;
  logic [7:0] rcv_byte = '0;
  logic       rcv_ok   = 1'b0;
  logic       rcv_err  = 1'b0;
  logic       overrun;
  logic [7:0] err_cnt;
  int         rcv_cnt  = 0;
  bit         mute     = 1'b0;

  rx_word_assembler_if word_if ();

  rx_word_assembler #(
    .TIMEOUT        (TIMEOUT),
    .WORDS_PER_BLOCK(WPB)
  ) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_rx      (rx),
    .o_rx_line (rx_line),
    .o_rx_rst_n(rx_rst_n),
    .i_rx_byte (rcv_byte),
    .i_rx_ok   (rcv_ok),
    .i_rx_error(rcv_err),
    .word_if   (word_if),
    .o_overrun (overrun),
    .o_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // Byte receiver: start bit at count 0, data LSB first at 1..8, stop at 9.
  always @(posedge clk) begin
    if (!rx_rst_n) begin
      rcv_cnt <= 0;
      rcv_ok  <= 1'b0;
      rcv_err <= 1'b0;
    end else if (rcv_cnt < 10) begin
      if (rcv_cnt >= 1 && rcv_cnt <= 8) rcv_byte[rcv_cnt-1] <= rx_line;
      if (rcv_cnt == 9 && !mute) begin
        rcv_ok  <= rx_line;
        rcv_err <= ~rx_line;
      end
      rcv_cnt <= rcv_cnt + 1;
    end
  end

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } xfer_t;

  xfer_t got_q[$];
  xfer_t exp_q[$];
  logic [7:0] m_pend[$];
  int m_words;
  int m_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Record every accepted word; sampled mid-cycle, consumed on the next edge.
  always @(negedge clk) begin
    if (!reset && word_if.word_valid && word_if.word_ready) begin
      got_q.push_back('{last: word_if.word_last, word: word_if.word});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pend.delete();
    m_words = 0;
    m_err   = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  // Reference: four consecutive good bytes make a word; a bad frame discards
  // the partial word; every WPB-th word closes a block.
  task automatic model_frame(input logic [7:0] b, input bit good);
    xfer_t x;
    if (!good) begin
      m_pend.delete();
      if (m_err < 255) m_err++;
    end else begin
      m_pend.push_back(b);
      if (m_pend.size() == 4) begin
        x.word = {m_pend[0], m_pend[1], m_pend[2], m_pend[3]};
        x.last = ((m_words % WPB) == WPB - 1);
        m_words++;
        exp_q.push_back(x);
        m_pend.delete();
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good, input int idle);
    rx = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick();
    end
    rx = good;
    tick();
    rx = 1'b1;
    repeat (idle) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit good);
    send_frame(b, good, 2);
    model_frame(b, good);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx    = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rx_line"},  32'(rx_line), 32'd1);
    check({tag, " rx_rst_n"}, 32'(rx_rst_n), 32'd0);
    check({tag, " word"},     word_if.word, 32'd0);
    check({tag, " valid"},    32'(word_if.word_valid), 32'd0);
    check({tag, " last"},     32'(word_if.word_last), 32'd0);
    check({tag, " overrun"},  32'(overrun), 32'd0);
    check({tag, " err_cnt"},  32'(err_cnt), 32'd0);
  endtask

  task automatic compare_q(input string tag);
    int n;
    check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s word%0d", tag, i), got_q[i].word, exp_q[i].word);
      check($sformatf("%s last%0d", tag, i), 32'(got_q[i].last), 32'(exp_q[i].last));
    end
  endtask

  typedef struct {
    logic [31:0] bytes;   // frame 0 in [31:24]
    logic [3:0]  good;    // bit j: frame j has a good stop bit
    int          n_words;
    logic [31:0] word;
    int          errs;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h61626380, 4'b1111, 1, 32'h61626380, 0};
    vecs[1] = '{32'h11223344, 4'b1101, 0, 32'h0,        1};
    vecs[2] = '{32'hDEADBEEF, 4'b0111, 0, 32'h0,        1};
    vecs[3] = '{32'h00FF00FF, 4'b1111, 1, 32'h00FF00FF, 0};
    vecs[4] = '{32'h12345678, 4'b1010, 0, 32'h0,        2};
    vecs[5] = '{32'hFFFFFFFF, 4'b1111, 1, 32'hFFFFFFFF, 0};

    word_if.word_ready = 1'b0;
    do_reset();
    check_reset_outputs("reset");

    // Table-driven four-frame groups, each from reset.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      word_if.word_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
        send_frame(vecs[v].bytes[31-8*j -: 8], vecs[v].good[j], 2);
      end
      tick();
      tick();
      check($sformatf("vec%0d words", v), 32'(got_q.size()), 32'(vecs[v].n_words));
      if (vecs[v].n_words == 1 && got_q.size() == 1) begin
        check($sformatf("vec%0d word", v), got_q[0].word, vecs[v].word);
        check($sformatf("vec%0d last", v), 32'(got_q[0].last), 32'd0);
      end
      check($sformatf("vec%0d err_cnt", v), 32'(err_cnt), 32'(vecs[v].errs));
    end

    // Word appears exactly at edge k+11 of the fourth frame.
    do_reset();
    word_if.word_ready = 1'b1;
    send_frame(8'h61, 1'b1, 2);
    send_frame(8'h62, 1'b1, 2);
    send_frame(8'h63, 1'b1, 2);
    send_frame(8'h80, 1'b1, 1);
    check("k+10 valid", 32'(word_if.word_valid), 32'd0);
    check("k+10 rx_rst_n", 32'(rx_rst_n), 32'd1);
    tick();
    check("k+11 valid", 32'(word_if.word_valid), 32'd1);
    check("k+11 word", word_if.word, 32'h61626380);
    check("k+11 last", 32'(word_if.word_last), 32'd0);
    check("k+11 err_cnt", 32'(err_cnt), 32'd0);
    check("k+11 rx_rst_n", 32'(rx_rst_n), 32'd0);
    tick();
    check("k+12 valid", 32'(word_if.word_valid), 32'd0);

    // One full block plus one word of the next.
    do_reset();
    word_if.word_ready = 1'b1;
    for (int i = 0; i < 68; i++) send(8'(i), 1'b1);
    tick();
    tick();
    compare_q("block");
    if (got_q.size() == 17) begin
      check("block w15 word", got_q[15].word, 32'h3C3D3E3F);
      check("block w15 last", 32'(got_q[15].last), 32'd1);
      check("block w16 last", 32'(got_q[16].last), 32'd0);
    end

    // Framing error discards the partial word.
    do_reset();
    word_if.word_ready = 1'b1;
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b1);
    send(8'hCC, 1'b1);
    send(8'hDD, 1'b1);
    tick();
    tick();
    compare_q("framerr");
    check("framerr err_cnt", 32'(err_cnt), 32'(m_err));
    if (got_q.size() == 1) check("framerr word", got_q[0].word, 32'hAABBCCDD);

    // Overrun: consumer stalled across two words.
    do_reset();
    word_if.word_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 2);
    check("ovr first valid", 32'(word_if.word_valid), 32'd1);
    check("ovr first word", word_if.word, 32'h01020304);
    check("ovr first flag", 32'(overrun), 32'd0);
    for (int i = 5; i <= 8; i++) send_frame(8'(i), 1'b1, 2);
    check("ovr held word", word_if.word, 32'h01020304);
    check("ovr held valid", 32'(word_if.word_valid), 32'd1);
    check("ovr flag", 32'(overrun), 32'd1);
    word_if.word_ready = 1'b1;
    tick();
    check("ovr drained valid", 32'(word_if.word_valid), 32'd0);
    check("ovr xfers", 32'(got_q.size()), 32'd1);
    for (int i = 9; i <= 12; i++) send_frame(8'(i), 1'b1, 2);
    tick();
    check("ovr after xfers", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("ovr after word", got_q[1].word, 32'h090A0B0C);
      check("ovr after last", 32'(got_q[1].last), 32'd0);
    end

    // Reset during data bit 4 of a frame, with overrun and word still set.
    rx = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      rx = 8'hA5 >> i;
      tick();
    end
    reset = 1'b1;
    rx    = 1'b0;
    tick();
    reset = 1'b0;
    rx    = 1'b1;
    check_reset_outputs("midreset");
    repeat (12) tick();
    model_reset();
    send(8'hC0, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hEE, 1'b1);
    send(8'h01, 1'b1);
    tick();
    tick();
    compare_q("postreset");

    // Receiver never answers: timeout after TIMEOUT cycles armed.
    do_reset();
    mute = 1'b1;
    rx   = 1'b0;
    tick();
    rx = 1'b1;
    check("tmo armed rx_rst_n", 32'(rx_rst_n), 32'd1);
    repeat (TIMEOUT - 1) tick();
    check("tmo early err_cnt", 32'(err_cnt), 32'd0);
    check("tmo early rx_rst_n", 32'(rx_rst_n), 32'd1);
    tick();
    check("tmo err_cnt", 32'(err_cnt), 32'd1);
    check("tmo rx_rst_n", 32'(rx_rst_n), 32'd0);
    tick();
    check("tmo idle rx_rst_n", 32'(rx_rst_n), 32'd0);
    check("tmo idle err_cnt", 32'(err_cnt), 32'd1);
    mute = 1'b0;

    // Random bytes, occasional bad stop bits, variable idle gaps.
    do_reset();
    word_if.word_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      bit         good;
      b    = 8'($urandom);
      good = ($urandom_range(0, 7) != 0);
      send_frame(b, good, $urandom_range(2, 4));
      model_frame(b, good);
    end
    tick();
    tick();
    compare_q("random");
    check("random err_cnt", 32'(err_cnt), 32'(m_err));

    // ErrCnt saturates.
    do_reset();
    for (int i = 0; i < 257; i++) send(8'h00, 1'b0);
    check("sat err_cnt", 32'(err_cnt), 32'(m_err));
    check("sat err_cnt max", 32'(err_cnt), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
